dest_reg_scoreboard: RTL and testbench
======================================

Name: dest_reg_scoreboard

Overview:
- Tracks outstanding writes to each of the 32 MIPS general-purpose registers.
- It consumes the 5-bit destination register number chosen by the write-register select (rt/rd) at issue, and the same number again at writeback.
- Decode queries it with the two source register numbers. It raises Stall while any used source has a write still in flight.
- Sits between the decode stage and the writeback stage as the hazard-detection back end.

Parameters:
NUM_REGS, 32, number of tracked architectural registers
REG_W, 5, register-number width
CNT_W, 2, per-register in-flight counter width (max 3 outstanding writes per register)

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high
IssueValid  input  1  an instruction with a destination register leaves decode this cycle
IssueReg  input  REG_W  destination register of the issuing instruction
RetireValid  input  1  writeback commits a register write this cycle
RetireReg  input  REG_W  destination register being written back
SrcA  input  REG_W  first source register (rs) of the instruction in decode
SrcB  input  REG_W  second source register (rt) of the instruction in decode
SrcAUsed  input  1  instruction in decode reads SrcA
SrcBUsed  input  1  instruction in decode reads SrcB
BusyA  output  1  SrcA has at least one pending write
BusyB  output  1  SrcB has at least one pending write
Stall  output  1  (SrcAUsed & BusyA) | (SrcBUsed & BusyB)
IssueFull  output  1  counter of IssueReg is at max (2^CNT_W - 1)
TotalPending  output  7  sum of all per-register counters
OverflowErr  output  1  sticky: an issue was attempted at max count
UnderflowErr  output  1  sticky: a retire was attempted at zero count

Behaviour:
- Reset, synchronous and active-high on the rising edge of Clk: all counters, TotalPending, OverflowErr and UnderflowErr go to 0. BusyA, BusyB, Stall and IssueFull therefore read 0 in the cycle after reset.
- Reset asserted mid-operation discards all pending state. Issue and retire inputs in that cycle are ignored.
- Register 0 is never tracked:
  - Issue and retire to reg 0 are ignored.
  - Neither sets an error flag.
  - BusyA and BusyB are 0 whenever the queried source is 0.
- Issue: when IssueValid and IssueReg != 0 and the count is below max, the count increments on the next edge.
- Retire: when RetireValid and RetireReg != 0 and the count is above 0, the count decrements on the next edge.
- Same register in the same cycle, both legal: count is unchanged. TotalPending is unchanged.
- Same register in the same cycle at max count: the retire is applied first, the issue is accepted, net count is unchanged, no overflow.
- Same register in the same cycle at zero count: the issue is accepted, the retire is rejected, count becomes 1, UnderflowErr is set.
- Different registers in the same cycle: both updates apply independently.
- Illegal issue (count at max and no same-cycle retire of that register): the issue is dropped and OverflowErr is set.
- Illegal retire (count 0): the retire is dropped and UnderflowErr is set.
- Error flags stay set until Reset.
- BusyA, BusyB, Stall and IssueFull are combinational from the registered counters. There is no bypass:
  - A same-cycle retire does not clear Busy that cycle.
  - A same-cycle issue does not set Busy until the next cycle.
- Latency: an issue at edge N gives Busy=1 from cycle N+1. A retire of the last pending write at edge M gives Busy=0 from cycle M+1.
- TotalPending tracks the sum exactly: +1 per accepted issue, -1 per accepted retire, net 0 when both are accepted. Maximum value is 31*3 = 93.
- SrcA == SrcB is legal; both Busy outputs then match.

Test Plan:
- Reset check: assert Reset 1 cycle, then idle. Required: BusyA=BusyB=Stall=0, TotalPending=0, both error flags 0.
- Basic hazard:
  - Stimulus: issue reg 8 in cycle 1; query SrcA=8, SrcAUsed=1 in cycle 2; retire reg 8 in cycle 3.
  - Required: Stall=1 in cycles 2-3, Stall=0 in cycle 4, TotalPending sequence 0,1,1,0.
- Saturation:
  - Stimulus: issue reg 5 on four consecutive cycles.
  - Required: count 3 after the third issue, IssueFull=1, fourth issue dropped, OverflowErr=1, TotalPending=3.
  - Then retire reg 5 three times. Required: BusyA (SrcA=5)=0 afterwards.
- Simultaneous events:
  - Issue and retire reg 12 in the same cycle at count 1. Required: count stays 1, Busy stays 1.
  - Same at count 0. Required: count becomes 1, UnderflowErr=1.
- Register 0 and unused sources:
  - Issue reg 0 and query SrcA=0. Required: BusyA=0, TotalPending=0, no error.
  - Issue reg 9 with SrcB=9, SrcBUsed=0. Required: BusyB=1, Stall=0.
- Mid-operation reset: with regs 3, 4 and 31 pending, assert Reset together with IssueValid on reg 3. Required: next cycle all counters 0, Busy=0 for 3, 4 and 31, error flags cleared.

Source files
------------

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: per-register in-flight write counters that
// drive decode-stage hazard stalls. Register 0 is never tracked.
module dest_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IssueValid,
  input  logic [REG_W-1:0] IssueReg,
  input  logic             RetireValid,
  input  logic [REG_W-1:0] RetireReg,
  input  logic [REG_W-1:0] SrcA,
  input  logic [REG_W-1:0] SrcB,
  input  logic             SrcAUsed,
  input  logic             SrcBUsed,
  output logic             BusyA,
  output logic             BusyB,
  output logic             Stall,
  output logic             IssueFull,
  output logic [6:0]       TotalPending,
  output logic             OverflowErr,
  output logic             UnderflowErr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  logic issue_req, retire_req, same_reg;
  logic issue_acc, retire_acc;
  logic overflow_evt, underflow_evt;

  always_comb begin
    issue_req  = IssueValid  && (IssueReg  != '0);
    retire_req = RetireValid && (RetireReg != '0);
    same_reg   = retire_req && (RetireReg == IssueReg);

    // A same-cycle retire frees the slot, so an issue at max is still taken.
    issue_acc  = issue_req && ((cnt_q[IssueReg] != CNT_MAX) || same_reg);
    retire_acc = retire_req && (cnt_q[RetireReg] != CNT_ZERO);

    overflow_evt  = issue_req  && !issue_acc;
    underflow_evt = retire_req && !retire_acc;

    cnt_d = cnt_q;
    // Modular add then subtract keeps the same-register case at net zero.
    if (issue_acc)
      cnt_d[IssueReg] = cnt_q[IssueReg] + CNT_ONE;
    if (retire_acc)
      cnt_d[RetireReg] = cnt_d[RetireReg] - CNT_ONE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt_q[i] <= '0;
      TotalPending <= '0;
      OverflowErr  <= 1'b0;
      UnderflowErr <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      TotalPending <= TotalPending + 7'(issue_acc) - 7'(retire_acc);
      if (overflow_evt)
        OverflowErr <= 1'b1;
      if (underflow_evt)
        UnderflowErr <= 1'b1;
    end
  end

  assign BusyA     = (SrcA != '0) && (cnt_q[SrcA] != CNT_ZERO);
  assign BusyB     = (SrcB != '0) && (cnt_q[SrcB] != CNT_ZERO);
  assign Stall     = (SrcAUsed && BusyA) || (SrcBUsed && BusyB);
  assign IssueFull = (cnt_q[IssueReg] == CNT_MAX);

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Directed bench for dest_reg_scoreboard: a per-register count model checked
// every cycle, plus hand-computed expectations along each scenario.
module tb_dest_reg_scoreboard;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       IssueValid = 1'b0;
  logic [4:0] IssueReg = '0;
  logic       RetireValid = 1'b0;
  logic [4:0] RetireReg = '0;
  logic [4:0] SrcA = '0;
  logic [4:0] SrcB = '0;
  logic       SrcAUsed = 1'b0;
  logic       SrcBUsed = 1'b0;
  logic       BusyA, BusyB, Stall, IssueFull;
  logic [6:0] TotalPending;
  logic       OverflowErr, UnderflowErr;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_cnt [32];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit m_iss, m_ret;

  dest_reg_scoreboard dut (
    .Clk(Clk), .Reset(Reset),
    .IssueValid(IssueValid), .IssueReg(IssueReg),
    .RetireValid(RetireValid), .RetireReg(RetireReg),
    .SrcA(SrcA), .SrcB(SrcB), .SrcAUsed(SrcAUsed), .SrcBUsed(SrcBUsed),
    .BusyA(BusyA), .BusyB(BusyB), .Stall(Stall), .IssueFull(IssueFull),
    .TotalPending(TotalPending), .OverflowErr(OverflowErr),
    .UnderflowErr(UnderflowErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: applies the issue/retire rules directly to a count per register.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_iss = IssueValid && IssueReg != 0;
      m_ret = RetireValid && RetireReg != 0;
      if (m_iss && m_ret && IssueReg == RetireReg) begin
        if (m_cnt[IssueReg] == 0) begin
          m_cnt[IssueReg] = 1;
          m_unf = 1'b1;
        end
      end else begin
        if (m_iss) begin
          if (m_cnt[IssueReg] == 3) m_ovf = 1'b1;
          else m_cnt[IssueReg]++;
        end
        if (m_ret) begin
          if (m_cnt[RetireReg] == 0) m_unf = 1'b1;
          else m_cnt[RetireReg]--;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      int sum;
      bit ba, bb;
      sum = 0;
      for (int i = 0; i < 32; i++) sum += m_cnt[i];
      ba = (SrcA != 0) && (m_cnt[SrcA] > 0);
      bb = (SrcB != 0) && (m_cnt[SrcB] > 0);
      chk("model_busya", BusyA, ba);
      chk("model_busyb", BusyB, bb);
      chk("model_stall", Stall, (SrcAUsed && ba) || (SrcBUsed && bb));
      chk("model_full", IssueFull, m_cnt[IssueReg] == 3);
      chk("model_total", TotalPending, sum);
      chk("model_ovf", OverflowErr, m_ovf);
      chk("model_unf", UnderflowErr, m_unf);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_in(input bit iv, input int ir, input bit rv, input int rr);
    IssueValid  = iv;
    IssueReg    = 5'(ir);
    RetireValid = rv;
    RetireReg   = 5'(rr);
  endtask

  initial begin
    // Reset check
    tick();
    Reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_stall", Stall, 0);
    chk("rst_busya", BusyA, 0);
    chk("rst_busyb", BusyB, 0);
    chk("rst_total", TotalPending, 0);
    chk("rst_ovf", OverflowErr, 0);
    chk("rst_unf", UnderflowErr, 0);

    // Basic hazard on reg 8
    set_in(1, 8, 0, 0);
    chk("haz_total_c1", TotalPending, 0);
    tick();
    set_in(0, 0, 0, 0);
    SrcA = 5'd8; SrcAUsed = 1'b1;
    #1;
    chk("haz_stall_c2", Stall, 1);
    chk("haz_total_c2", TotalPending, 1);
    tick();
    set_in(0, 0, 1, 8);
    #1;
    chk("haz_stall_c3", Stall, 1);
    chk("haz_total_c3", TotalPending, 1);
    tick();
    set_in(0, 0, 0, 0);
    #1;
    chk("haz_stall_c4", Stall, 0);
    chk("haz_total_c4", TotalPending, 0);

    // Register 0 is ignored, including a retire at zero
    SrcA = 5'd0; SrcAUsed = 1'b1;
    set_in(1, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0);
    #1;
    chk("r0_busya", BusyA, 0);
    chk("r0_total", TotalPending, 0);
    tick();
    set_in(0, 0, 0, 0);
    #1;
    chk("r0_ovf", OverflowErr, 0);
    chk("r0_unf", UnderflowErr, 0);

    // Same-cycle issue+retire at max count on reg 6
    SrcA = 5'd6; SrcAUsed = 1'b0;
    repeat (3) begin set_in(1, 6, 0, 0); tick(); end
    chk("max_full", IssueFull, 1);
    set_in(1, 6, 1, 6);
    tick();
    chk("max_total", TotalPending, 3);
    chk("max_full_after", IssueFull, 1);
    chk("max_no_ovf", OverflowErr, 0);
    repeat (3) begin set_in(0, 6, 1, 6); tick(); end
    set_in(0, 0, 0, 0);
    #1;
    chk("max_drained", BusyA, 0);

    // Same-cycle issue+retire on reg 12 at count 1, then at count 0
    SrcB = 5'd12;
    set_in(1, 12, 0, 0); tick();
    set_in(1, 12, 1, 12); tick();
    set_in(0, 0, 0, 0);
    #1;
    chk("sim1_busyb", BusyB, 1);
    chk("sim1_total", TotalPending, 1);
    chk("sim1_unf", UnderflowErr, 0);
    set_in(0, 0, 1, 12); tick();
    set_in(1, 12, 1, 12); tick();
    set_in(0, 0, 0, 0);
    #1;
    chk("sim0_busyb", BusyB, 1);
    chk("sim0_total", TotalPending, 1);
    chk("sim0_unf", UnderflowErr, 1);
    set_in(0, 0, 1, 12); tick();

    // Saturation on reg 5
    SrcA = 5'd5; SrcAUsed = 1'b1;
    repeat (3) begin set_in(1, 5, 0, 0); tick(); end
    chk("sat_full", IssueFull, 1);
    chk("sat_total3", TotalPending, 3);
    chk("sat_no_ovf_yet", OverflowErr, 0);
    tick();
    chk("sat_ovf", OverflowErr, 1);
    chk("sat_total_after", TotalPending, 3);
    repeat (3) begin set_in(0, 0, 1, 5); tick(); end
    set_in(0, 0, 0, 0);
    #1;
    chk("sat_busya_clear", BusyA, 0);
    chk("sat_total0", TotalPending, 0);

    // Unused source: reg 9 on SrcB with SrcBUsed=0
    SrcAUsed = 1'b0;
    SrcB = 5'd9; SrcBUsed = 1'b0;
    set_in(1, 9, 0, 0); tick();
    set_in(0, 0, 0, 0);
    #1;
    chk("unused_busyb", BusyB, 1);
    chk("unused_stall", Stall, 0);

    // Different registers in one cycle, then mid-operation reset
    set_in(1, 3, 1, 9); tick();
    set_in(1, 4, 0, 0); tick();
    set_in(1, 31, 0, 0); tick();
    SrcA = 5'd3; SrcB = 5'd9;
    set_in(0, 0, 0, 0);
    #1;
    chk("diff_busya3", BusyA, 1);
    chk("diff_busyb9", BusyB, 0);
    chk("pre_rst_total", TotalPending, 3);
    SrcB = 5'd4;
    Reset = 1'b1;
    set_in(1, 3, 0, 0);
    tick();
    Reset = 1'b0;
    set_in(0, 0, 0, 0);
    #1;
    chk("mrst_busy3", BusyA, 0);
    chk("mrst_busy4", BusyB, 0);
    SrcA = 5'd31;
    #1;
    chk("mrst_busy31", BusyA, 0);
    chk("mrst_total", TotalPending, 0);
    chk("mrst_ovf", OverflowErr, 0);
    chk("mrst_unf", UnderflowErr, 0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
